// File: rtl/frac_sad_search.sv
// Fractional motion search for one CU: streams padded reference rows through an
// 8-row window, forms integer / horizontal half-pel / vertical half-pel candidates
// with the 8-tap HEVC filter, and accumulates one SAD per candidate.
//
// Handshakes: a row transfers on a rising edge where in_valid && in_ready; results
// are offered while out_valid is high and are taken on a rising edge where
// out_valid && out_ack. Both sides may stall indefinitely.
module frac_sad_search #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int BITDEPTH  = 8,
    parameter int TAPS      = 8,
    parameter int HALF_TAPS = 3,
    parameter int SAD_W     = 14
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [(WIDTH+TAPS)*BITDEPTH-1:0] filter_pix,
    input  logic [WIDTH*BITDEPTH-1:0]        ref_pix,
    output logic                             out_valid,
    input  logic                             out_ack,
    output logic [SAD_W-1:0]                 sad_int,
    output logic [SAD_W-1:0]                 sad_h,
    output logic [SAD_W-1:0]                 sad_v,
    output logic [1:0]                       best_mode,
    output logic [SAD_W-1:0]                 best_sad,
    output logic [2:0]                       dbg_state
);

    localparam int ROW_W    = (WIDTH + TAPS) * BITDEPTH;
    localparam int LAST_ROW = HEIGHT + TAPS - 2;
    localparam int CW       = $clog2(HEIGHT + TAPS);
    localparam int AW       = BITDEPTH + 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [AW-1:0] RND     = AW'(32);
    localparam logic signed [AW-1:0] PIX_MAX = AW'((1 << BITDEPTH) - 1);

    // 8-tap half-pel filter (-1,4,-11,40,40,-11,4,-1), rounded, clipped to pixel range
    function automatic logic [BITDEPTH-1:0] filt8(input logic [TAPS*BITDEPTH-1:0] p);
        logic signed [AW-1:0] px [TAPS];
        logic signed [AW-1:0] o, m, i;
        logic signed [AW-1:0] acc;
        for (int t = 0; t < TAPS; t++) begin
            px[t] = $signed({{10{1'b0}}, p[t*BITDEPTH +: BITDEPTH]});
        end
        o   = px[0] + px[7];
        m   = px[1] + px[6];
        i   = px[2] + px[5];
        acc = px[3] + px[4];
        acc = (acc <<< 5) + (acc <<< 3) - ((i <<< 3) + (i <<< 1) + i) + (m <<< 2) - o;
        acc = (acc + RND) >>> 6;
        if (acc[AW-1]) begin
            return '0;
        end else if (acc > PIX_MAX) begin
            return '1;
        end else begin
            return acc[BITDEPTH-1:0];
        end
    endfunction

    function automatic logic [BITDEPTH-1:0] absdiff(input logic [BITDEPTH-1:0] a,
                                                     input logic [BITDEPTH-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       row_q, row_d;
    logic                accept;
    logic                ack_take;

    logic [ROW_W-1:0]    win_q [TAPS-1];
    logic [ROW_W-1:0]    nw    [TAPS];
    logic [TAPS*BITDEPTH-1:0] vcol [WIDTH];

    logic [BITDEPTH-1:0] cand_int [WIDTH];
    logic [BITDEPTH-1:0] cand_h   [WIDTH];
    logic [BITDEPTH-1:0] cand_v   [WIDTH];
    logic [BITDEPTH-1:0] d_int_q  [WIDTH];
    logic [BITDEPTH-1:0] d_h_q    [WIDTH];
    logic [BITDEPTH-1:0] d_v_q    [WIDTH];
    logic                s1_valid_q;

    logic [SAD_W-1:0]    rs_int, rs_h, rs_v;
    logic [SAD_W-1:0]    acc_int_q, acc_h_q, acc_v_q;
    logic [1:0]          best_mode_c;
    logic [SAD_W-1:0]    best_sad_c;

    logic                out_valid_q;
    logic [SAD_W-1:0]    sad_int_q, sad_h_q, sad_v_q, best_sad_q;
    logic [1:0]          best_mode_q;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_CALC);
    assign accept    = in_valid && in_ready;
    assign ack_take  = (state_q == S_DONE) && out_valid_q && out_ack;
    assign dbg_state = state_q;

    // Next-state and row-counter logic of the block sequencer
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (accept) begin
            row_d = (row_q == CW'(LAST_ROW)) ? '0 : row_q + 1'b1;
        end
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FILL;
            S_FILL:  if (accept && row_q == CW'(TAPS - 2)) state_d = S_CALC;
            S_CALC:  if (accept && row_q == CW'(LAST_ROW)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (ack_take) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Candidate formation on the window as it will look once the incoming row is in
    always_comb begin
        for (int r = 0; r < TAPS - 1; r++) begin
            nw[r] = win_q[r];
        end
        nw[TAPS-1] = filter_pix;
        for (int x = 0; x < WIDTH; x++) begin
            for (int t = 0; t < TAPS; t++) begin
                vcol[x][t*BITDEPTH +: BITDEPTH] = nw[t][(x+HALF_TAPS)*BITDEPTH +: BITDEPTH];
            end
            cand_int[x] = nw[HALF_TAPS][(x+HALF_TAPS)*BITDEPTH +: BITDEPTH];
            cand_h[x]   = filt8(nw[HALF_TAPS][x*BITDEPTH +: TAPS*BITDEPTH]);
            cand_v[x]   = filt8(vcol[x]);
        end
    end

    // Line-buffer window: shifts only on an accepted row
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < TAPS - 1; r++) win_q[r] <= '0;
        end else if (accept) begin
            for (int r = 0; r < TAPS - 2; r++) win_q[r] <= win_q[r+1];
            win_q[TAPS-2] <= filter_pix;
        end
    end

    // Stage 1: per-pixel absolute differences for rows that produce output
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            for (int x = 0; x < WIDTH; x++) begin
                d_int_q[x] <= '0;
                d_h_q[x]   <= '0;
                d_v_q[x]   <= '0;
            end
        end else begin
            s1_valid_q <= accept && (state_q == S_CALC);
            if (accept && state_q == S_CALC) begin
                for (int x = 0; x < WIDTH; x++) begin
                    d_int_q[x] <= absdiff(cand_int[x], ref_pix[x*BITDEPTH +: BITDEPTH]);
                    d_h_q[x]   <= absdiff(cand_h[x],   ref_pix[x*BITDEPTH +: BITDEPTH]);
                    d_v_q[x]   <= absdiff(cand_v[x],   ref_pix[x*BITDEPTH +: BITDEPTH]);
                end
            end
        end
    end

    // Row sums of stage-1 differences and winner selection on the accumulators
    always_comb begin
        rs_int = '0;
        rs_h   = '0;
        rs_v   = '0;
        for (int x = 0; x < WIDTH; x++) begin
            rs_int = rs_int + SAD_W'(d_int_q[x]);
            rs_h   = rs_h   + SAD_W'(d_h_q[x]);
            rs_v   = rs_v   + SAD_W'(d_v_q[x]);
        end
        best_mode_c = 2'd0;
        best_sad_c  = acc_int_q;
        if (acc_h_q < best_sad_c) begin
            best_mode_c = 2'd1;
            best_sad_c  = acc_h_q;
        end
        if (acc_v_q < best_sad_c) begin
            best_mode_c = 2'd2;
            best_sad_c  = acc_v_q;
        end
    end

    // Stage 2: accumulate row sums; clear when the result is taken
    always_ff @(posedge clk) begin
        if (reset || ack_take) begin
            acc_int_q <= '0;
            acc_h_q   <= '0;
            acc_v_q   <= '0;
        end else if (s1_valid_q) begin
            acc_int_q <= acc_int_q + rs_int;
            acc_h_q   <= acc_h_q   + rs_h;
            acc_v_q   <= acc_v_q   + rs_v;
        end
    end

    // Result registers: captured on the first DONE cycle, held until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sad_int_q   <= '0;
            sad_h_q     <= '0;
            sad_v_q     <= '0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
        end else if (ack_take) begin
            out_valid_q <= 1'b0;
        end else if (state_q == S_DONE && !out_valid_q) begin
            out_valid_q <= 1'b1;
            sad_int_q   <= acc_int_q;
            sad_h_q     <= acc_h_q;
            sad_v_q     <= acc_v_q;
            best_mode_q <= best_mode_c;
            best_sad_q  <= best_sad_c;
        end
    end

    assign out_valid = out_valid_q;
    assign sad_int   = sad_int_q;
    assign sad_h     = sad_h_q;
    assign sad_v     = sad_v_q;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_frac_sad_search.sv
// Directed and randomized blocks for frac_sad_search, checked against a
// pixel-level arithmetic model of the three candidate SADs.
module tb_frac_sad_search;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int BD   = 8;
    localparam int T    = 8;
    localparam int NR   = H + T - 1;
    localparam int PW   = W + T;
    localparam int SW   = 14;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PW*BD-1:0]  filter_pix;
    logic [W*BD-1:0]   ref_pix;
    logic              out_valid;
    logic              out_ack;
    logic [SW-1:0]     sad_int, sad_h, sad_v, best_sad;
    logic [1:0]        best_mode;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    int blk_pix [NR][PW];
    int blk_ref [H][W];
    int exp_int, exp_h, exp_v, exp_mode, exp_best;

    frac_sad_search dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .filter_pix(filter_pix), .ref_pix(ref_pix), .out_valid(out_valid),
        .out_ack(out_ack), .sad_int(sad_int), .sad_h(sad_h), .sad_v(sad_v),
        .best_mode(best_mode), .best_sad(best_sad), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int half(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7);
        int s;
        s = -a0 + 4*a1 - 11*a2 + 40*a3 + 40*a4 - 11*a5 + 4*a6 - a7;
        return clip((s + 32) >>> 6);
    endfunction

    // reference model: SAD of every candidate over the whole CU
    task automatic model();
        int ci, ch, cv, r;
        exp_int = 0; exp_h = 0; exp_v = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                r  = blk_ref[y][x];
                ci = blk_pix[y+3][x+3];
                ch = half(blk_pix[y+3][x], blk_pix[y+3][x+1], blk_pix[y+3][x+2], blk_pix[y+3][x+3],
                          blk_pix[y+3][x+4], blk_pix[y+3][x+5], blk_pix[y+3][x+6], blk_pix[y+3][x+7]);
                cv = half(blk_pix[y][x+3], blk_pix[y+1][x+3], blk_pix[y+2][x+3], blk_pix[y+3][x+3],
                          blk_pix[y+4][x+3], blk_pix[y+5][x+3], blk_pix[y+6][x+3], blk_pix[y+7][x+3]);
                exp_int += (ci > r) ? ci - r : r - ci;
                exp_h   += (ch > r) ? ch - r : r - ch;
                exp_v   += (cv > r) ? cv - r : r - cv;
            end
        end
        exp_mode = 0; exp_best = exp_int;
        if (exp_h < exp_best) begin exp_mode = 1; exp_best = exp_h; end
        if (exp_v < exp_best) begin exp_mode = 2; exp_best = exp_v; end
    endtask

    // pattern 0 flat, 1 row ramp, 2 column ramp, 3 random
    task automatic make_block(input int pat, input int flat, input int ref_off);
        for (int k = 0; k < NR; k++) begin
            for (int i = 0; i < PW; i++) begin
                case (pat)
                    0: blk_pix[k][i] = flat;
                    1: blk_pix[k][i] = 10 * i;
                    2: blk_pix[k][i] = 10 * k;
                    default: blk_pix[k][i] = $urandom_range(255, 0);
                endcase
            end
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (pat)
                    0: blk_ref[y][x] = flat - ref_off;
                    1: blk_ref[y][x] = 10 * x + 35;
                    2: blk_ref[y][x] = 10 * y + 35;
                    default: blk_ref[y][x] = $urandom_range(255, 0);
                endcase
            end
        end
    endtask

    // driver: send rows 0..nrows-1 with optional idle gaps carrying junk data
    task automatic drive_block(input int gap_pct, input int nrows);
        int n;
        for (int k = 0; k < nrows; k++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                @(negedge clk);
                in_valid   = 1'b0;
                filter_pix = {$urandom(), $urandom(), $urandom(), $urandom()};
                ref_pix    = {$urandom(), $urandom()};
                @(posedge clk);
            end
            @(negedge clk);
            check("no_early_out_valid", out_valid, 0);
            for (int i = 0; i < PW; i++) filter_pix[i*BD +: BD] = blk_pix[k][i][BD-1:0];
            if (k >= T - 1) begin
                for (int x = 0; x < W; x++) ref_pix[x*BD +: BD] = blk_ref[k-(T-1)][x][BD-1:0];
            end else begin
                ref_pix = {$urandom(), $urandom()};
            end
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("in_ready_timeout", in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // after the last row: fixed result latency then result comparison
    task automatic check_result(input string tag);
        check({tag, "_ov_lat0"}, out_valid, 0);
        check({tag, "_rdy_drain"}, in_ready, 0);
        @(negedge clk);
        check({tag, "_ov_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_ov_lat2"}, out_valid, 1);
        model();
        check({tag, "_sad_int"}, sad_int, exp_int);
        check({tag, "_sad_h"}, sad_h, exp_h);
        check({tag, "_sad_v"}, sad_v, exp_v);
        check({tag, "_best_mode"}, best_mode, exp_mode);
        check({tag, "_best_sad"}, best_sad, exp_best);
    endtask

    // hold the result for hold_cycles, then take it
    task automatic ack_result(input string tag, input int hold_cycles);
        logic [4*SW+1:0] snap;
        snap = {sad_int, sad_h, sad_v, best_mode, best_sad};
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_stable"}, {sad_int, sad_h, sad_v, best_mode, best_sad}, snap);
        end
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ack = 1'b0;
        check({tag, "_ov_cleared"}, out_valid, 0);
        check({tag, "_ready_after_ack"}, in_ready, 1);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ack    = 1'b0;
        filter_pix = '0;
        ref_pix    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sad_int", sad_int, 0);
        check("rst_best_mode", best_mode, 0);
        check("rst_best_sad", best_sad, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // stray ack outside DONE is ignored
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("stray_ack", out_valid, 0);

        // flat, zero SAD
        make_block(0, 100, 0);
        drive_block(0, NR);
        check_result("t1");
        ack_result("t1", 0);

        // flat offset, three-way tie
        make_block(0, 100, 10);
        drive_block(0, NR);
        check_result("t2");
        ack_result("t2", 1);

        // horizontal ramp: H half-pel exact
        make_block(1, 0, 0);
        drive_block(0, NR);
        check_result("t3");
        ack_result("t3", 0);

        // vertical ramp: V half-pel exact
        make_block(2, 0, 0);
        drive_block(0, NR);
        check_result("t4");
        ack_result("t4", 0);

        // horizontal ramp with input gaps and delayed ack
        make_block(1, 0, 0);
        drive_block(40, NR);
        check_result("t5");
        ack_result("t5", 10);

        // abort after 9 rows, then a clean flat block
        make_block(0, 100, 0);
        drive_block(0, 9);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_sad_h", sad_h, 0);
        check("t6_rst_ready", in_ready, 1);
        drive_block(0, NR);
        check_result("t6");
        ack_result("t6", 0);

        // random blocks, random gaps
        for (int b = 0; b < 4; b++) begin
            make_block(3, 0, 0);
            drive_block($urandom_range(30, 0), NR);
            check_result("rand");
            ack_result("rand", $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
